// File: rtl/usr_serial_receiver_if.sv
// Serial-link receive side bundle: bit strobe/data in, parallel word handshake and status out.
interface usr_serial_receiver_if #(
    parameter int WIDTH = 6
);
    logic             SEN;
    logic             SIN;
    logic             DREADY;
    logic [WIDTH-1:0] DOUT;
    logic             DVALID;
    logic             PERR;
    logic             FERR;
    logic             OVR;
    logic             BUSY;

    modport master (
        output SEN, SIN, DREADY,
        input  DOUT, DVALID, PERR, FERR, OVR, BUSY
    );

    modport slave (
        input  SEN, SIN, DREADY,
        output DOUT, DVALID, PERR, FERR, OVR, BUSY
    );
endinterface

// File: rtl/usr_serial_receiver.sv
// Frame receiver for an MSB-first shift-left serial stream: start detect, deserialise,
// even-parity and stop check, then hands the word to a valid/ready consumer.
module usr_serial_receiver #(
    parameter int WIDTH     = 6,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic                 Clk,
    input  logic                 reset,
    usr_serial_receiver_if.slave rx
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shreg;
    logic             par_ok;
    logic [WIDTH-1:0] dout;
    logic             dvalid;
    logic             perr;
    logic             ferr;
    logic             ovr;
    logic             busy;

    logic accept;
    logic last_bit;

    assign accept   = dvalid & rx.DREADY;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    assign rx.DOUT   = dout;
    assign rx.DVALID = dvalid;
    assign rx.PERR   = perr;
    assign rx.FERR   = ferr;
    assign rx.OVR    = ovr;
    assign rx.BUSY   = busy;

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            shreg  <= '0;
            par_ok <= 1'b1;
            dout   <= '0;
            dvalid <= 1'b0;
            perr   <= 1'b0;
            ferr   <= 1'b0;
            ovr    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            perr <= 1'b0;
            ferr <= 1'b0;
            // A plain accept drains the word and clears overrun; a delivery on the
            // same edge below overrides both.
            if (accept) begin
                dvalid <= 1'b0;
                ovr    <= 1'b0;
            end
            if (rx.SEN) begin
                case (state)
                    IDLE: begin
                        if (!rx.SIN) begin
                            state <= DATA;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg <= {shreg[WIDTH-2:0], rx.SIN};
                        cnt   <= cnt + 1'b1;
                        if (last_bit)
                            state <= PARITY_EN ? PARITY : STOP;
                    end
                    PARITY: begin
                        par_ok <= ~((^shreg) ^ rx.SIN);
                        state  <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        // Framing error outranks parity; either one discards the word.
                        if (!rx.SIN) begin
                            ferr <= 1'b1;
                        end else if (PARITY_EN && !par_ok) begin
                            perr <= 1'b1;
                        end else if (!dvalid || rx.DREADY) begin
                            dout   <= shreg;
                            dvalid <= 1'b1;
                            ovr    <= ovr;
                        end else begin
                            ovr <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_usr_serial_receiver.sv
// Randomised frame stimulus checked cycle by cycle against a frame-level reference model.
module tb_usr_serial_receiver;
    localparam int W = 6;
    localparam int K_NONE = 0, K_START = 1, K_GOOD = 2, K_PERR = 3, K_FERR = 4;

    logic Clk = 1'b0;
    logic reset = 1'b0;

    usr_serial_receiver_if #(.WIDTH(W)) bus ();

    usr_serial_receiver #(.WIDTH(W), .PARITY_EN(1'b1)) dut (
        .Clk   (Clk),
        .reset (reset),
        .rx    (bus.slave)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    // reference model of the consumer-visible state
    logic [W-1:0] m_dout;
    logic m_dvalid, m_perr, m_ferr, m_ovr, m_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".DOUT"},   32'(bus.DOUT),   32'(m_dout));
        chk({tag, ".DVALID"}, 32'(bus.DVALID), 32'(m_dvalid));
        chk({tag, ".PERR"},   32'(bus.PERR),   32'(m_perr));
        chk({tag, ".FERR"},   32'(bus.FERR),   32'(m_ferr));
        chk({tag, ".OVR"},    32'(bus.OVR),    32'(m_ovr));
        chk({tag, ".BUSY"},   32'(bus.BUSY),   32'(m_busy));
    endtask

    task automatic model_reset();
        m_dout = '0; m_dvalid = 0; m_perr = 0; m_ferr = 0; m_ovr = 0; m_busy = 0;
    endtask

    // One clock: drive, step the model with the frame-level meaning of this edge, compare.
    task automatic cyc(input logic sen, input logic sin, input logic rdy,
                       input int kind, input logic [W-1:0] w, input string tag);
        bit acc;
        bus.SEN = sen; bus.SIN = sin; bus.DREADY = rdy;
        @(posedge Clk);
        acc = m_dvalid && rdy;
        m_perr = (kind == K_PERR);
        m_ferr = (kind == K_FERR);
        if (kind == K_GOOD) begin
            if (!m_dvalid || rdy) begin
                m_dout = w; m_dvalid = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (acc) begin
            m_dvalid = 0; m_ovr = 0;
        end
        if (kind == K_START) m_busy = 1;
        if (kind >= K_GOOD)  m_busy = 0;
        #1;
        check_all(tag);
    endtask

    function automatic logic rdy_pick(input int mode);
        return (mode == 2) ? logic'($urandom_range(0, 1)) : (mode == 1);
    endfunction

    // rm: DREADY mode for body cycles, rs: for the stop strobe (0 low, 1 high, 2 random)
    task automatic send_frame(input logic [W-1:0] w, input logic pbad, input logic stop,
                              input int rm, input int rs, input int gap_at, input int gap_n,
                              input string tag);
        logic bits [W+3];
        int kind;
        bits[0] = 1'b0;
        for (int i = 0; i < W; i++) bits[i+1] = w[W-1-i];
        bits[W+1] = (^w) ^ pbad;
        bits[W+2] = stop;
        for (int i = 0; i < W + 3; i++) begin
            if (i == gap_at)
                repeat (gap_n) cyc(1'b0, logic'($urandom_range(0, 1)), rdy_pick(rm), K_NONE, w, tag);
            if (i == 0)           kind = K_START;
            else if (i == W + 2)  kind = !stop ? K_FERR : (pbad ? K_PERR : K_GOOD);
            else                  kind = K_NONE;
            cyc(1'b1, bits[i], (i == W + 2) ? rdy_pick(rs) : rdy_pick(rm), kind, w, tag);
        end
    endtask

    initial begin
        logic [W-1:0] w;
        bus.SEN = 0; bus.SIN = 1; bus.DREADY = 0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1 check_all("reset");
        reset = 1'b1;

        // good frame held, then accepted
        send_frame(6'b101010, 0, 1, 0, 0, -1, 0, "good");
        repeat (3) cyc(1'b1, 1'b1, 1'b0, K_NONE, '0, "hold");
        cyc(1'b0, 1'b1, 1'b1, K_NONE, '0, "accept");
        cyc(1'b0, 1'b1, 1'b0, K_NONE, '0, "drained");

        send_frame(6'b110011, 1, 1, 0, 0, -1, 0, "perr");
        cyc(1'b1, 1'b1, 1'b0, K_NONE, '0, "perr_after");
        send_frame(6'b000111, 0, 0, 0, 0, -1, 0, "ferr");
        cyc(1'b1, 1'b1, 1'b0, K_NONE, '0, "ferr_after");

        // overrun, then delivery together with accept, then a plain accept
        send_frame(6'b101010, 0, 1, 0, 0, -1, 0, "ovr_a");
        send_frame(6'b010101, 0, 1, 0, 0, -1, 0, "ovr_b");
        send_frame(6'b111111, 0, 1, 0, 1, -1, 0, "ovr_c");
        cyc(1'b1, 1'b1, 1'b1, K_NONE, '0, "ovr_clear");

        // full-rate back-to-back, consumer always ready
        for (int n = 0; n < 6; n++) begin
            w = W'($urandom);
            send_frame(w, 0, 1, 1, 1, -1, 0, "b2b");
        end
        send_frame(6'b011010, 0, 1, 1, 1, 3, 5, "gap");

        // randomised frames, errors, gaps and consumer backpressure
        for (int n = 0; n < 40; n++) begin
            w = W'($urandom);
            send_frame(w, ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) != 0), 2, 2,
                       ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, W + 2)) : -1,
                       int'($urandom_range(1, 4)), "rand");
            repeat ($urandom_range(0, 2))
                cyc(logic'($urandom_range(0, 1)), 1'b1, rdy_pick(2), K_NONE, '0, "rand_idle");
        end

        // async reset mid-frame with a pending word, then a clean frame
        send_frame(6'b001100, 0, 1, 0, 0, -1, 0, "pre_rst");
        cyc(1'b1, 1'b0, 1'b0, K_START, '0, "abort");
        cyc(1'b1, 1'b1, 1'b0, K_NONE, '0, "abort");
        cyc(1'b1, 1'b0, 1'b0, K_NONE, '0, "abort");
        cyc(1'b1, 1'b1, 1'b0, K_NONE, '0, "abort");
        #2 reset = 1'b0;
        model_reset();
        #1 check_all("async_rst");
        #1 reset = 1'b1;
        send_frame(6'b100001, 0, 1, 0, 0, -1, 0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
